// File: rtl/axi_write_slave_burst.sv
// AXI3 write-channel slave: one burst in flight, beats forwarded to a
// local device port, FIXED/INCR/WRAP sequencing, one B response per burst.
module axi_write_slave_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic [DATA_W-1:0]   dev_data,
    output logic [DATA_W/8-1:0] dev_strb,
    output logic                dev_valid,
    input  logic                dev_ready
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [3:0]        len_q;
    logic [3:0]        cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err;

    logic              beat;
    logic              last_beat;
    logic              beat_err;
    logic              aw_err;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wmask;
    logic [ADDR_W-1:0] amask;
    logic [ADDR_W-1:0] next_addr;

    assign AWREADY   = ARESETn && (state == IDLE);
    assign WREADY    = ARESETn && (state == DATA) && (err || dev_ready);
    assign dev_valid = ARESETn && (state == DATA) && !err && WVALID;
    assign dev_data  = WDATA;
    assign dev_strb  = WSTRB;

    assign beat      = WVALID && WREADY;
    assign last_beat = (cnt == len_q);
    // WLAST must coincide exactly with the AWLEN-counted final beat
    assign beat_err  = (WID != id_q) || (WLAST != last_beat);

    assign step  = ADDR_W'(1) << size_q;
    assign wmask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    assign amask = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);

    always_comb begin
        aw_err = (AWSIZE > MAX_SIZE) || (AWBURST == 2'b11);
        if (AWBURST == 2'b10) begin
            if (!(AWLEN == 4'd1 || AWLEN == 4'd3 ||
                  AWLEN == 4'd7 || AWLEN == 4'd15))
                aw_err = 1'b1;
            if ((AWADDR & amask) != '0)
                aw_err = 1'b1;
        end
    end

    // WRAP window is a power of two, so base alignment is a mask
    always_comb begin
        next_addr = dev_addr;
        unique case (burst_q)
            2'b01:   next_addr = dev_addr + step;
            2'b10:   next_addr = (dev_addr & ~wmask) |
                                 ((dev_addr + step) & wmask);
            default: next_addr = dev_addr;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= IDLE;
            BVALID   <= 1'b0;
            BRESP    <= 2'b00;
            BID      <= '0;
            cnt      <= 4'd0;
            err      <= 1'b0;
            dev_addr <= '0;
            id_q     <= '0;
            len_q    <= 4'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (AWVALID) begin
                        id_q     <= AWID;
                        dev_addr <= AWADDR;
                        len_q    <= AWLEN;
                        size_q   <= AWSIZE;
                        burst_q  <= AWBURST;
                        cnt      <= 4'd0;
                        err      <= aw_err;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt      <= cnt + 4'd1;
                        dev_addr <= next_addr;
                        if (beat_err)
                            err <= 1'b1;
                        if (last_beat) begin
                            state  <= RESP;
                            BVALID <= 1'b1;
                            BID    <= id_q;
                            BRESP  <= (err || beat_err) ? 2'b10 : 2'b00;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave_burst.sv
// Bench for axi_write_slave_burst: directed bursts, burst-level model
// of forwarded beats and B responses, per-cycle compare on the outputs.
module tb_axi_write_slave_burst;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [IW-1:0]   AWID;
    logic [AW-1:0]   AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [IW-1:0]   WID;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   dev_addr;
    logic [DW-1:0]   dev_data;
    logic [DW/8-1:0] dev_strb;
    logic            dev_valid;
    logic            dev_ready;

    always #5 ACLK = ~ACLK;

    axi_write_slave_burst #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dev_addr(dev_addr), .dev_data(dev_data), .dev_strb(dev_strb),
        .dev_valid(dev_valid), .dev_ready(dev_ready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    wr_t         exp_q[$];
    b_t          exp_b[$];
    logic [31:0] seen[$];
    logic [1:0]  last_bresp = 2'b11;
    logic [3:0]  last_bid = 4'h0;

    logic [3:0]  b_id;
    logic [3:0]  b_len;
    logic [31:0] b_addr;
    logic [2:0]  b_size;
    logic [1:0]  b_burst;
    int          bad_wid;
    int          wlast_at;
    logic [3:0]  rdy_pat;
    bit          chk_wready;
    int          cyc;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic setup(input logic [3:0] id, input logic [31:0] addr,
                         input int len, input int size, input logic [1:0] bt);
        b_id       = id;
        b_addr     = addr;
        b_len      = 4'(len);
        b_size     = 3'(size);
        b_burst    = bt;
        bad_wid    = -1;
        wlast_at   = len;
        rdy_pat    = 4'hF;
        chk_wready = 1'b0;
    endtask

    function automatic logic [31:0] beat_data(input int i);
        return {8'hD0, 4'h0, b_id, b_addr[7:0], 8'(i)};
    endfunction

    function automatic logic [3:0] beat_strb(input int i);
        return 4'hF >> (i % 4);
    endfunction

    function automatic logic [31:0] beat_addr(input int i);
        longint bytes = longint'(1) << b_size;
        longint win   = (longint'(b_len) + 1) * bytes;
        longint a     = longint'(b_addr);
        longint base;
        case (b_burst)
            2'b00:   return b_addr;
            2'b01:   return 32'((a + i * bytes) % (longint'(1) << 32));
            default: begin
                base = a - (a % win);
                return 32'(base + ((a - base + i * bytes) % win));
            end
        endcase
    endfunction

    task automatic plan();
        longint bytes = longint'(1) << b_size;
        bit err;
        err = (b_size > 3'd2) || (b_burst == 2'b11) ||
              (b_burst == 2'b10 && !(int'(b_len) inside {1, 3, 7, 15})) ||
              (b_burst == 2'b10 && (longint'(b_addr) % bytes) != 0);
        for (int i = 0; i <= int'(b_len); i++) begin
            if (!err)
                exp_q.push_back('{beat_addr(i), beat_data(i), beat_strb(i)});
            if (i == bad_wid || ((i == wlast_at) != (i == int'(b_len))))
                err = 1'b1;
        end
        exp_b.push_back('{b_id, err ? 2'b10 : 2'b00});
        seen.delete();
    endtask

    always @(negedge ACLK) begin
        if (ARESETn === 1'b1) begin
            if (dev_valid) begin
                if (exp_q.size() == 0) begin
                    check("dev_valid_unexpected", dev_valid, 0);
                end else begin
                    check("dev_addr", dev_addr, exp_q[0].addr);
                    check("dev_data", dev_data, exp_q[0].data);
                    check("dev_strb", dev_strb, exp_q[0].strb);
                    if (dev_ready) begin
                        seen.push_back(dev_addr);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (BVALID) begin
                if (exp_b.size() == 0) begin
                    check("bvalid_unexpected", BVALID, 0);
                end else begin
                    check("bid", BID, exp_b[0].id);
                    check("bresp", BRESP, exp_b[0].resp);
                    if (BREADY) begin
                        last_bresp = BRESP;
                        last_bid   = BID;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive_aw();
        AWVALID = 1'b1;
        AWID    = b_id;
        AWADDR  = b_addr;
        AWLEN   = b_len;
        AWSIZE  = b_size;
        AWBURST = b_burst;
    endtask

    task automatic aw_phase();
        bit hs = 1'b0;
        drive_aw();
        for (int c = 0; c < 20 && !hs; c++) begin
            #1;
            hs = AWREADY;
            step();
        end
        AWVALID = 1'b0;
        check("aw_handshake", hs, 1);
        #1;
        check("dev_addr_start", dev_addr, b_addr);
    endtask

    task automatic data_phase(input int nbeats, output int cycles);
        int beats = 0;
        bit hs;
        cycles = 0;
        while (beats < nbeats && cycles < 200) begin
            WVALID    = 1'b1;
            WID       = (beats == bad_wid) ? (b_id ^ 4'h1) : b_id;
            WLAST     = (beats == wlast_at);
            WDATA     = beat_data(beats);
            WSTRB     = beat_strb(beats);
            dev_ready = rdy_pat[cycles % 4];
            #1;
            if (chk_wready)
                check("wready_mirror", WREADY, dev_ready);
            hs = WREADY;
            step();
            cycles++;
            if (hs)
                beats++;
        end
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        dev_ready = 1'b1;
        check("beats_accepted", beats, nbeats);
    endtask

    task automatic b_phase(input int delay);
        bit hs = 1'b0;
        #1;
        check("bvalid_latency", BVALID, 1);
        for (int d = 1; d < delay; d++) begin
            step();
            #1;
            check("bvalid_held", BVALID, 1);
        end
        if (delay > 0)
            step();
        BREADY = 1'b1;
        for (int c = 0; c < 20 && !hs; c++) begin
            #1;
            hs = BVALID;
            step();
        end
        BREADY = 1'b0;
        check("b_handshake", hs, 1);
        #1;
        check("bvalid_cleared", BVALID, 0);
    endtask

    task automatic run_burst(input int delay, output int cycles);
        plan();
        aw_phase();
        data_phase(int'(b_len) + 1, cycles);
        b_phase(delay);
        check("fwd_drained", exp_q.size(), 0);
        check("b_drained", exp_b.size(), 0);
    endtask

    task automatic check_seen(input int n, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3);
        logic [31:0] e[4];
        e = '{a0, a1, a2, a3};
        check("seen_count", seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            check("seen_addr", seen[i], e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn   = 1'b0;
        AWVALID   = 1'b0;
        AWID      = '0;
        AWADDR    = '0;
        AWLEN     = '0;
        AWSIZE    = '0;
        AWBURST   = '0;
        WVALID    = 1'b0;
        WID       = '0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        dev_ready = 1'b1;
        repeat (2) @(posedge ACLK);
        #2;
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_dev_valid", dev_valid, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_bid", BID, 0);
        check("rst_dev_addr", dev_addr, 0);
        ARESETn = 1'b1;
        #1;
        check("idle_awready", AWREADY, 1);

        setup(4'h5, 32'h100, 3, 2, 2'b01);
        run_burst(0, cyc);
        check("incr_cycles", cyc, 4);
        check_seen(4, 32'h100, 32'h104, 32'h108, 32'h10C);
        check("incr_bresp", last_bresp, 2'b00);
        check("incr_bid", last_bid, 4'h5);

        setup(4'h2, 32'h1C, 3, 2, 2'b10);
        run_burst(0, cyc);
        check_seen(4, 32'h1C, 32'h10, 32'h14, 32'h18);
        check("wrap_bresp", last_bresp, 2'b00);

        setup(4'h7, 32'hFFFF_FFF8, 3, 2, 2'b01);
        run_burst(0, cyc);
        check_seen(4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);

        setup(4'h9, 32'h200, 3, 2, 2'b01);
        rdy_pat    = 4'b1001;
        chk_wready = 1'b1;
        run_burst(5, cyc);
        check("bp_cycles", cyc, 8);
        check_seen(4, 32'h200, 32'h204, 32'h208, 32'h20C);
        check("bp_bresp", last_bresp, 2'b00);

        setup(4'h1, 32'h300, 3, 3, 2'b01);
        run_burst(0, cyc);
        check_seen(0, 0, 0, 0, 0);
        check("size_err_bresp", last_bresp, 2'b10);

        setup(4'h4, 32'h400, 3, 2, 2'b01);
        wlast_at = 1;
        run_burst(0, cyc);
        check_seen(2, 32'h400, 32'h404, 0, 0);
        check("wlast_err_bresp", last_bresp, 2'b10);

        setup(4'h6, 32'h500, 3, 2, 2'b01);
        bad_wid = 1;
        run_burst(0, cyc);
        check_seen(2, 32'h500, 32'h504, 0, 0);
        check("wid_err_bresp", last_bresp, 2'b10);

        setup(4'h3, 32'h16, 3, 2, 2'b10);
        run_burst(0, cyc);
        check("wrap_align_bresp", last_bresp, 2'b10);

        setup(4'h8, 32'h20, 2, 2, 2'b10);
        run_burst(0, cyc);
        check("wrap_len_bresp", last_bresp, 2'b10);

        setup(4'hA, 32'h20, 1, 2, 2'b11);
        run_burst(0, cyc);
        check("rsvd_burst_bresp", last_bresp, 2'b10);

        setup(4'hB, 32'h600, 3, 2, 2'b01);
        plan();
        aw_phase();
        data_phase(2, cyc);
        ARESETn = 1'b0;
        #1;
        check("midrst_awready", AWREADY, 0);
        check("midrst_wready", WREADY, 0);
        check("midrst_dev_valid", dev_valid, 0);
        step();
        ARESETn = 1'b1;
        exp_q.delete();
        exp_b.delete();
        #1;
        check("postrst_bvalid", BVALID, 0);
        check("postrst_awready", AWREADY, 1);
        repeat (3) begin
            step();
            #1;
            check("postrst_no_b", BVALID, 0);
        end
        setup(4'hC, 32'h700, 0, 2, 2'b01);
        run_burst(0, cyc);
        check_seen(1, 32'h700, 0, 0, 0);
        check("postrst_bresp", last_bresp, 2'b00);

        setup(4'hD, 32'h80, 2, 2, 2'b00);
        run_burst(0, cyc);
        check_seen(3, 32'h80, 32'h80, 32'h80, 0);
        check("fixed_bresp", last_bresp, 2'b00);

        setup(4'h3, 32'h40, 0, 2, 2'b00);
        plan();
        aw_phase();
        data_phase(1, cyc);
        #1;
        check("fixed0_bvalid", BVALID, 1);
        check_seen(1, 32'h40, 0, 0, 0);
        setup(4'h6, 32'h340, 1, 2, 2'b01);
        plan();
        BREADY = 1'b1;
        drive_aw();
        check("awready_in_resp", AWREADY, 0);
        step();
        BREADY = 1'b0;
        #1;
        check("fixed0_bresp", last_bresp, 2'b00);
        check("fixed0_bid", last_bid, 4'h3);
        check("aw_next_cycle", AWREADY, 1);
        check("b_done_bvalid", BVALID, 0);
        step();
        AWVALID = 1'b0;
        #1;
        check("overlap_dev_addr", dev_addr, 32'h340);
        data_phase(2, cyc);
        b_phase(0);
        check_seen(2, 32'h340, 32'h344, 0, 0);
        check("overlap_bresp", last_bresp, 2'b00);
        check("overlap_bid", last_bid, 4'h6);
        check("final_fwd_drained", exp_q.size(), 0);
        check("final_b_drained", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
